loc_sram_ctrl: RTL and testbench

Sequencing and arbitration controller for the 256-row x (D x BW)-bit locality SRAM.
- After reset, zero-initialises every row.
- Serves two requesters: a single-element update port (write one BW-bit entry of a row) and a row-read port with optional clear-after-read.
- Owns the SRAM write and read ports. Read and update proceed in the same cycle; only clear-after-read and update contend for the write port.

---
 rtl/loc_sram_ctrl.sv | 139 +++++++++++++
 tb/tb_loc_sram_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loc_sram_ctrl.sv
// Locality SRAM controller: zero-initialises every row after reset, then
// arbitrates a single-element update port against a row-read port with
// optional clear-after-read. All SRAM-facing outputs are registered.
module loc_sram_ctrl #(
   parameter int ADDR_SPACE = 8,
   parameter int BW         = 5,
   parameter int D          = 256,
   parameter int VID_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [ADDR_SPACE-1:0] upd_row,
   input  logic [VID_W-1:0]      upd_vid,
   input  logic [BW-1:0]         upd_val,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_SPACE-1:0] rd_row,
   input  logic                  rd_clr,
   output logic                  rsp_valid,
   output logic [D*BW-1:0]       rsp_data,
   output logic                  init_done,
   output logic                  sram_wsb,
   output logic [D-1:0]          sram_bytemask,
   output logic [D*BW-1:0]       sram_wdata,
   output logic [ADDR_SPACE-1:0] sram_waddr,
   output logic [ADDR_SPACE-1:0] sram_raddr,
   input  logic [D*BW-1:0]       sram_rdata
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   typedef enum logic {RR_READ, RR_UPD} rr_t;

   localparam logic [ADDR_SPACE-1:0] LAST_ROW = '1;

   state_t                state, state_nxt;
   rr_t                   rr, rr_nxt;
   logic [ADDR_SPACE-1:0] cnt, cnt_nxt;
   logic                  rd_pend;
   logic                  conflict, upd_fire, rd_fire;
   logic                  init_done_nxt;
   logic                  wsb_nxt;
   logic [D-1:0]          mask_nxt;
   logic [D*BW-1:0]       wdata_nxt;
   logic [ADDR_SPACE-1:0] waddr_nxt, raddr_nxt;
   logic [VID_W-1:0]      slot;
   int unsigned           slot_lsb;

   // Response data is the SRAM's registered read port passed straight through.
   assign rsp_data = sram_rdata;

   // Next-state, arbitration and next SRAM command selection.
   always_comb begin
      state_nxt     = state;
      rr_nxt        = rr;
      cnt_nxt       = cnt;
      init_done_nxt = init_done;
      upd_ready     = 1'b0;
      rd_ready      = 1'b0;
      conflict      = 1'b0;
      upd_fire      = 1'b0;
      rd_fire       = 1'b0;
      wsb_nxt       = 1'b1;
      mask_nxt      = '1;
      wdata_nxt     = '0;
      waddr_nxt     = sram_waddr;
      raddr_nxt     = sram_raddr;
      // Element i lives in the mirrored slot D-1-i.
      slot          = VID_W'(D - 1) - upd_vid;
      slot_lsb      = int'(slot) * BW;
      case (state)
         ST_INIT: begin
            wsb_nxt   = 1'b0;
            mask_nxt  = '0;
            waddr_nxt = cnt;
            cnt_nxt   = cnt + 1'b1;
            if (cnt == LAST_ROW) begin
               state_nxt     = ST_RUN;
               init_done_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            // Each ready looks only at the other port's valid, so neither
            // ready depends combinationally on its own valid.
            conflict  = upd_valid & rd_valid & rd_clr;
            upd_ready = ~(rd_valid & rd_clr) | (rr == RR_UPD);
            rd_ready  = ~(upd_valid & rd_clr) | (rr == RR_READ);
            upd_fire  = upd_valid & upd_ready;
            rd_fire   = rd_valid & rd_ready;
            if (conflict)
               rr_nxt = (rr == RR_READ) ? RR_UPD : RR_READ;
            if (rd_fire)
               raddr_nxt = rd_row;
            if (rd_fire && rd_clr) begin
               wsb_nxt   = 1'b0;
               mask_nxt  = '0;
               waddr_nxt = rd_row;
            end else if (upd_fire) begin
               wsb_nxt                      = 1'b0;
               waddr_nxt                    = upd_row;
               mask_nxt[slot]               = 1'b0;
               wdata_nxt[slot_lsb +: BW]    = upd_val;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   // State, pointer, registered SRAM command and response pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_INIT;
         rr            <= RR_READ;
         cnt           <= '0;
         init_done     <= 1'b0;
         sram_wsb      <= 1'b1;
         sram_bytemask <= '1;
         sram_wdata    <= '0;
         sram_waddr    <= '0;
         sram_raddr    <= '0;
         rd_pend       <= 1'b0;
         rsp_valid     <= 1'b0;
      end else begin
         state         <= state_nxt;
         rr            <= rr_nxt;
         cnt           <= cnt_nxt;
         init_done     <= init_done_nxt;
         sram_wsb      <= wsb_nxt;
         sram_bytemask <= mask_nxt;
         sram_wdata    <= wdata_nxt;
         sram_waddr    <= waddr_nxt;
         sram_raddr    <= raddr_nxt;
         rd_pend       <= rd_fire;
         rsp_valid     <= rd_pend;
      end
   end

endmodule

// File: tb/tb_loc_sram_ctrl.sv
// Self-checking bench for loc_sram_ctrl with a behavioural SRAM and a
// scoreboard of expected read responses (data and arrival edge).
module tb_loc_sram_ctrl;

   localparam int ADDR_SPACE = 8;
   localparam int BW         = 5;
   localparam int D          = 256;
   localparam int VID_W      = 8;
   localparam int ROWS       = 1 << ADDR_SPACE;

   typedef struct {
      logic [D*BW-1:0] data;
      int unsigned     edge_no;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  upd_valid = 1'b0;
   logic                  upd_ready;
   logic [ADDR_SPACE-1:0] upd_row = '0;
   logic [VID_W-1:0]      upd_vid = '0;
   logic [BW-1:0]         upd_val = '0;
   logic                  rd_valid = 1'b0;
   logic                  rd_ready;
   logic [ADDR_SPACE-1:0] rd_row = '0;
   logic                  rd_clr = 1'b0;
   logic                  rsp_valid;
   logic [D*BW-1:0]       rsp_data;
   logic                  init_done;
   logic                  sram_wsb;
   logic [D-1:0]          sram_bytemask;
   logic [D*BW-1:0]       sram_wdata;
   logic [ADDR_SPACE-1:0] sram_waddr;
   logic [ADDR_SPACE-1:0] sram_raddr;
   logic [D*BW-1:0]       sram_rdata;

   int          checks = 0;
   int          errors = 0;
   int unsigned edge_cnt = 0;
   exp_t        q[$];
   logic [D*BW-1:0] ref_mem [0:ROWS-1];
   logic [D*BW-1:0] mem [0:ROWS-1];
   logic [D*BW-1:0] wr_row;
   logic        last_upd_acc, last_rd_acc;

   loc_sram_ctrl #(
      .ADDR_SPACE(ADDR_SPACE),
      .BW(BW),
      .D(D),
      .VID_W(VID_W)
   ) dut (
      .clk(clk), .rst(rst),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_row(upd_row),
      .upd_vid(upd_vid), .upd_val(upd_val),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row), .rd_clr(rd_clr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
      .sram_wsb(sram_wsb), .sram_bytemask(sram_bytemask), .sram_wdata(sram_wdata),
      .sram_waddr(sram_waddr), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Behavioural SRAM: registered read, masked write, read-before-write.
   always @(posedge clk) begin
      sram_rdata <= mem[sram_raddr];
      if (!sram_wsb) begin
         wr_row = mem[sram_waddr];
         for (int i = 0; i < D; i++)
            if (!sram_bytemask[i]) wr_row[i*BW +: BW] = sram_wdata[i*BW +: BW];
         mem[sram_waddr] <= wr_row;
      end
   end

   task automatic set_idle();
      upd_valid = 1'b0;
      rd_valid  = 1'b0;
      rd_clr    = 1'b0;
   endtask

   // One clock: check response at negedge, record acceptances, then step past the edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (rsp_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid high at edge %0d with nothing pending", edge_cnt);
         end else begin
            e = q.pop_front();
            if (rsp_data !== e.data || edge_cnt != e.edge_no) begin
               errors++;
               $display("FAIL rsp: edge got %0d expected %0d, differing bits %0d, data[79:0] got %h expected %h",
                        edge_cnt, e.edge_no, $countones(rsp_data ^ e.data), rsp_data[79:0], e.data[79:0]);
            end
         end
      end else if (q.size() > 0 && edge_cnt >= q[0].edge_no) begin
         checks++;
         errors++;
         $display("FAIL rsp_missing: rsp_valid low at edge %0d expected at %0d", edge_cnt, q[0].edge_no);
         void'(q.pop_front());
      end
      last_upd_acc = upd_valid & upd_ready;
      last_rd_acc  = rd_valid & rd_ready;
      if (last_rd_acc) begin
         e.data    = ref_mem[rd_row];
         e.edge_no = edge_cnt + 2;
         q.push_back(e);
         if (rd_clr) ref_mem[rd_row] = '0;
      end
      if (last_upd_acc)
         ref_mem[upd_row][(D - 1 - int'(upd_vid)) * BW +: BW] = upd_val;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_idle();
      for (int i = 0; i < 10 && q.size() > 0; i++) tick();
      tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic check_reset_vals(input string name);
      checks++;
      if (sram_wsb !== 1'b1 || sram_bytemask !== '1 || sram_wdata !== '0 ||
          sram_waddr !== '0 || sram_raddr !== '0 || rsp_valid !== 1'b0 ||
          init_done !== 1'b0 || upd_ready !== 1'b0 || rd_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s: wsb=%b mask_ones=%0d wdata_ones=%0d waddr=%0d raddr=%0d rsp_valid=%b init_done=%b rdy=%b%b, expected 1/256/0/0/0/0/0/00",
                  name, sram_wsb, $countones(sram_bytemask), $countones(sram_wdata),
                  sram_waddr, sram_raddr, rsp_valid, init_done, upd_ready, rd_ready);
      end
   endtask

   // Called just after reset release at a negedge; the next posedge is edge 1.
   task automatic check_init(input string name);
      upd_valid = 1'b1;
      rd_valid  = 1'b1;
      rd_clr    = 1'b1;
      for (int e = 1; e <= ROWS; e++) begin
         @(negedge clk);
         checks++;
         if (sram_wsb !== 1'b0 || sram_waddr !== ADDR_SPACE'(e - 1) ||
             sram_bytemask !== '0 || sram_wdata !== '0 || init_done !== (e == ROWS)) begin
            errors++;
            $display("FAIL %s edge %0d: wsb=%b waddr=%0d mask_ones=%0d wdata_ones=%0d init_done=%b, expected 0/%0d/0/0/%b",
                     name, e, sram_wsb, sram_waddr, $countones(sram_bytemask),
                     $countones(sram_wdata), init_done, e - 1, e == ROWS);
         end
         if (e < ROWS) begin
            checks++;
            if (upd_ready !== 1'b0 || rd_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s_ready edge %0d: upd_ready=%b rd_ready=%b expected 0 0",
                        name, e, upd_ready, rd_ready);
            end
         end else begin
            set_idle();
         end
      end
      @(negedge clk);
      checks++;
      if (sram_wsb !== 1'b1 || sram_bytemask !== '1) begin
         errors++;
         $display("FAIL %s_after: wsb=%b mask_ones=%0d expected 1 and 256",
                  name, sram_wsb, $countones(sram_bytemask));
      end
      for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      repeat (3) @(negedge clk);
      check_reset_vals("reset_state");
      rst = 1'b0;
      repeat (100) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("reset_mid_init");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_init("init_after_mid_reset");
   endtask

   task automatic test_update_read();
      logic [D-1:0]    exp_mask;
      logic [D*BW-1:0] exp_wdata;
      exp_mask       = '1;
      exp_mask[255]  = 1'b0;
      exp_wdata      = '0;
      exp_wdata[1279:1275] = 5'h1B;
      upd_valid = 1'b1; upd_row = 8'd3; upd_vid = 8'd0; upd_val = 5'h1B;
      tick();
      checks++;
      if (!last_upd_acc || sram_wsb !== 1'b0 || sram_waddr !== 8'd3 ||
          sram_bytemask !== exp_mask || sram_wdata !== exp_wdata) begin
         errors++;
         $display("FAIL update_cmd: acc=%b wsb=%b waddr=%0d mask=%h wdata[1279:1270]=%h wdata_ones=%0d, expected acc=1 wsb=0 waddr=3 mask=%h wdata[1279:1270]=%h",
                  last_upd_acc, sram_wsb, sram_waddr, sram_bytemask, sram_wdata[1279:1270],
                  $countones(sram_wdata), exp_mask, exp_wdata[1279:1270]);
      end
      set_idle();
      rd_valid = 1'b1; rd_row = 8'd3;
      tick();
      drain();
   endtask

   task automatic test_clear_read();
      rd_valid = 1'b1; rd_row = 8'd3; rd_clr = 1'b1;
      tick();
      checks++;
      if (!last_rd_acc || sram_wsb !== 1'b0 || sram_waddr !== 8'd3 ||
          sram_bytemask !== '0 || sram_wdata !== '0 || sram_raddr !== 8'd3) begin
         errors++;
         $display("FAIL clear_cmd: acc=%b wsb=%b waddr=%0d raddr=%0d mask_ones=%0d wdata_ones=%0d, expected 1/0/3/3/0/0",
                  last_rd_acc, sram_wsb, sram_waddr, sram_raddr,
                  $countones(sram_bytemask), $countones(sram_wdata));
      end
      rd_clr = 1'b0;
      tick();
      drain();
   endtask

   task automatic test_arbitration();
      logic exp_rd [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      upd_valid = 1'b1; upd_row = 8'd10; upd_vid = 8'd2; upd_val = 5'h03;
      rd_valid  = 1'b1; rd_row  = 8'd10; rd_clr  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (last_rd_acc !== exp_rd[i] || last_upd_acc !== !exp_rd[i]) begin
            errors++;
            $display("FAIL arb_grant %0d: rd_acc=%b upd_acc=%b expected %b %b",
                     i, last_rd_acc, last_upd_acc, exp_rd[i], !exp_rd[i]);
         end
      end
      // A lone clearing read is not a conflict and leaves the pointer alone.
      upd_valid = 1'b0;
      tick();
      checks++;
      if (last_rd_acc !== 1'b1) begin
         errors++;
         $display("FAIL arb_noconflict: rd_acc=%b expected 1", last_rd_acc);
      end
      upd_valid = 1'b1;
      tick();
      checks++;
      if (last_rd_acc !== 1'b1 || last_upd_acc !== 1'b0) begin
         errors++;
         $display("FAIL arb_ptr_held: rd_acc=%b upd_acc=%b expected 1 0", last_rd_acc, last_upd_acc);
      end
      drain();
   endtask

   task automatic test_same_edge();
      upd_valid = 1'b1; upd_row = 8'd7; upd_vid = 8'd255; upd_val = 5'h1F;
      rd_valid  = 1'b1; rd_row  = 8'd7; rd_clr  = 1'b0;
      tick();
      checks++;
      if (last_rd_acc !== 1'b1 || last_upd_acc !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_accept: rd_acc=%b upd_acc=%b expected 1 1", last_rd_acc, last_upd_acc);
      end
      upd_valid = 1'b0;
      tick();
      drain();
      checks++;
      if (ref_mem[7][4:0] !== 5'h1F) begin
         errors++;
         $display("FAIL same_edge_model: row7[4:0]=%h expected 1f", ref_mem[7][4:0]);
      end
   endtask

   task automatic test_back_to_back();
      upd_valid = 1'b1; upd_row = 8'd200; upd_vid = 8'd128; upd_val = 5'h0A;
      tick();
      upd_valid = 1'b0;
      rd_valid = 1'b1;
      rd_row = 8'd200; tick();
      rd_row = 8'd7;   tick();
      rd_row = 8'd3;   tick();
      rd_row = 8'd255; tick();
      drain();
   endtask

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      test_update_read();
      test_clear_read();
      test_arbitration();
      test_same_edge();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
